// File: rtl/three2one_sc.sv
`timescale 1ns/1ps
// Registered 2-of-3 majority voter for three switch inputs.
// Each input is synchronized and debounced, then voted, and disagreement is flagged.
module three2one_sc #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       result,
  output logic       disagree,
  output logic [2:0] minority
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0] raw;
  logic [2:0] s;
  logic [2:0] d;

  assign raw = {c, b, a};

  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   d_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], raw[g]};
      end
    end

    assign s[g] = sync[SYNC_STAGES-1];

    // Any return to the accepted level clears the count, so short pulses never land.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q <= 1'b0;
        cnt <= '0;
      end else if (s[g] == d_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        d_q <= s[g];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign d[g] = d_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= 1'b0;
      disagree <= 1'b0;
      minority <= '0;
    end else begin
      result      <= (d[0] & d[1]) | (d[0] & d[2]) | (d[1] & d[2]);
      disagree    <= !((d[0] == d[1]) && (d[1] == d[2]));
      minority[0] <= (d[1] == d[2]) & (d[0] != d[1]);
      minority[1] <= (d[0] == d[2]) & (d[1] != d[0]);
      minority[2] <= (d[0] == d[1]) & (d[2] != d[0]);
    end
  end

endmodule

// File: tb/tb_three2one_sc.sv
`timescale 1ns/1ps
// Scoreboard bench for three2one_sc: default instance plus a SYNC_STAGES=3,
// DEBOUNCE_CYCLES=1 instance, each with its own expectation queue.
module tb_three2one_sc;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic a2 = 1'b0, b2 = 1'b0, c2 = 1'b0;
  logic r0, d0, r1, d1;
  logic [2:0] m0, m1;

  always #5 clk = ~clk;

  three2one_sc dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .result(r0), .disagree(d0), .minority(m0)
  );

  three2one_sc #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .c(c2),
    .result(r1), .disagree(d1), .minority(m1)
  );

  typedef struct {
    int         due;
    logic       r;
    logic       d;
    logic [2:0] m;
  } exp_t;

  typedef struct packed {
    logic [2:0] abc;
    logic       r;
    logic       d;
    logic [2:0] m;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t prev0, prev1, e0, e1;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
    end
  endtask

  task automatic check_entry(input string tag, input exp_t e, input logic r,
                             input logic d, input logic [2:0] m);
    if (e.due != cyc) begin
      total++;
      bad++;
      $display("FAIL %s missed due=%0d cyc=%0d", tag, e.due, cyc);
    end else begin
      chk({tag, ".result"},   {2'b00, r}, {2'b00, e.r});
      chk({tag, ".disagree"}, {2'b00, d}, {2'b00, e.d});
      chk({tag, ".minority"}, m, e.m);
    end
  endtask

  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].due <= cyc) begin
      e0 = q0.pop_front();
      check_entry("dut0", e0, r0, d0, m0);
    end
    while (q1.size() > 0 && q1[0].due <= cyc) begin
      e1 = q1.pop_front();
      check_entry("dut1", e1, r1, d1, m1);
    end
  end

  task automatic push(input int which, input int due, input logic r,
                      input logic d, input logic [2:0] m);
    exp_t e;
    e.due = due; e.r = r; e.d = d; e.m = m;
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Called at a negedge; checks the output one cycle before and exactly at the latency.
  task automatic apply(input vec_t v, input bit both);
    int m;
    m = cyc;
    {a, b, c} = v.abc;
    push(0, m + 6, prev0.r, prev0.d, prev0.m);
    push(0, m + 7, v.r, v.d, v.m);
    push(0, m + 9, v.r, v.d, v.m);
    prev0.r = v.r; prev0.d = v.d; prev0.m = v.m;
    if (both) begin
      {a2, b2, c2} = v.abc;
      push(1, m + 4, prev1.r, prev1.d, prev1.m);
      push(1, m + 5, v.r, v.d, v.m);
      push(1, m + 7, v.r, v.d, v.m);
      prev1.r = v.r; prev1.d = v.d; prev1.m = v.m;
    end
    repeat (10) @(negedge clk);
  endtask

  // Pulse b on dut0 from an all-zero settled state; a 4-cycle pulse just survives.
  task automatic pulse_b(input int len);
    int m;
    m = cyc;
    b = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      if (len == 4 && i >= 7 && i <= 10) push(0, m + i, 1'b0, 1'b1, 3'b010);
      else push(0, m + i, 1'b0, 1'b0, 3'b000);
    end
    repeat (len) @(negedge clk);
    b = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  vec_t vecs[10];
  vec_t v111;

  initial begin
    prev0.due = 0; prev0.r = 0; prev0.d = 0; prev0.m = 3'b000;
    prev1 = prev0;
    vecs[0] = {3'b101, 1'b1, 1'b1, 3'b010};
    vecs[1] = {3'b111, 1'b1, 1'b0, 3'b000};
    vecs[2] = {3'b000, 1'b0, 1'b0, 3'b000};
    vecs[3] = {3'b100, 1'b0, 1'b1, 3'b001};
    vecs[4] = {3'b010, 1'b0, 1'b1, 3'b010};
    vecs[5] = {3'b001, 1'b0, 1'b1, 3'b100};
    vecs[6] = {3'b000, 1'b0, 1'b0, 3'b000};
    vecs[7] = {3'b110, 1'b1, 1'b1, 3'b100};
    vecs[8] = {3'b011, 1'b1, 1'b1, 3'b001};
    vecs[9] = {3'b000, 1'b0, 1'b0, 3'b000};
    v111    = {3'b111, 1'b1, 1'b0, 3'b000};

    #2 rst_n = 1'b0;
    #1;
    chk("rst0.outs", {r0, d0, m0[0]}, 3'b000);
    chk("rst0.min", m0, 3'b000);
    chk("rst1.outs", {r1, d1, m1[0]}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    apply(v111, 1'b1);

    // Asynchronous reset mid-cycle while settled at 1/1/1.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst0.result", {2'b00, r0}, 3'b000);
    chk("midrst0.disagree", {2'b00, d0}, 3'b000);
    chk("midrst0.min", m0, 3'b000);
    chk("midrst1.result", {2'b00, r1}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int m;
      m = cyc;
      push(0, m + 6, 1'b0, 1'b0, 3'b000);
      push(0, m + 7, 1'b1, 1'b0, 3'b000);
      push(1, m + 4, 1'b0, 1'b0, 3'b000);
      push(1, m + 5, 1'b1, 1'b0, 3'b000);
    end
    repeat (10) @(negedge clk);

    for (int i = 0; i < 10; i++) apply(vecs[i], 1'b1);

    pulse_b(3);
    pulse_b(4);

    for (int i = 0; i < 60 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    if (q0.size() > 0 || q1.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d/%0d", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
